// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the two-entry skid pipeline stage.
// State encoding doubles as the occupancy count so decode stays trivial.
package pipe_skid_reg_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic logic [OCC_W-1:0] occ_of(input state_t st);
    case (st)
      ST_BUSY: occ_of = OCC_W'(1);
      ST_FULL: occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready bus for the skid stage: upstream (s_*), downstream (m_*),
// synchronous flush and the occupancy status.
interface pipe_skid_reg_if
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 18
);

  logic                  clr;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [OCC_W-1:0]      occupancy;

  // The stage itself.
  modport slave (
    input  clr,
    input  s_valid,
    output s_ready,
    input  s_data,
    output m_valid,
    input  m_ready,
    output m_data,
    output occupancy
  );

  // The surrounding datapath: producer, consumer and flush control.
  modport master (
    output clr,
    output s_valid,
    input  s_ready,
    output s_data,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  occupancy
  );

endinterface

// File: rtl/pipe_data_reg.sv
// Data word register with load enable; asynchronous active-high reset to zero.
module pipe_data_reg #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ld,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline stage: main register drives m_data, skid register
// catches the word accepted while the consumer stalls. All outputs are flops.
//
// state    | meaning
// ST_EMPTY | nothing held, m_valid 0, s_ready 1
// ST_BUSY  | main holds the head word, s_ready 1
// ST_FULL  | main and skid both hold words, s_ready 0
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 18
) (
  input logic             clk,
  input logic             rst,
  pipe_skid_reg_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_m_valid;
  logic             w_m_valid_nxt;
  logic             r_s_ready;
  logic             w_s_ready_nxt;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_main_ld;
  logic                  w_main_from_skid;
  logic                  w_skid_ld;
  logic [DATA_WIDTH-1:0] w_main_d;
  logic [DATA_WIDTH-1:0] w_main_q;
  logic [DATA_WIDTH-1:0] w_skid_q;

  // Handshakes use the registered ready/valid, so m_ready never reaches s_ready.
  assign w_push = bus.s_valid & r_s_ready;
  assign w_pop  = r_m_valid & bus.m_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;

    if (bus.clr) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_main_ld   = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_push && w_pop) begin
            w_main_ld = 1'b1;
          end else if (w_push) begin
            w_skid_ld   = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_BUSY;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end

    // Output flops are loaded from the next state so they switch with it.
    w_m_valid_nxt = (w_state_nxt != ST_EMPTY);
    w_s_ready_nxt = (w_state_nxt != ST_FULL);
    w_occ_nxt     = occ_of(w_state_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b1;
      r_occ     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_occ     <= w_occ_nxt;
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : bus.s_data;

  pipe_data_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_ld (w_main_ld),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  pipe_data_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_ld (w_skid_ld),
    .i_d  (bus.s_data),
    .o_q  (w_skid_q)
  );

  assign bus.s_ready   = r_s_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = w_main_q;
  assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue model of a two-deep FIFO checked every
// negedge, plus directed scenarios with literal expectations.
module tb_pipe_skid_reg;

  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  pipe_skid_reg_if #(.DATA_WIDTH(DW)) bus ();

  pipe_skid_reg #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: the stage is a FIFO of capacity two; the head is on m_data, and
  // m_data keeps the last head once the FIFO drains.
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_head = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      last_head = '0;
    end else begin
      automatic bit push = bus.s_valid && (q.size() < 2);
      automatic bit pop  = bus.m_ready && (q.size() > 0);
      if (bus.clr) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(bus.s_data);
      end
      if (q.size() > 0) last_head = q[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
      chk("model s_ready", 32'(bus.s_ready), 32'(q.size() < 2));
      chk("model occupancy", 32'(bus.occupancy), 32'(q.size()));
      chk("model m_data", 32'(bus.m_data), 32'((q.size() != 0) ? q[0] : last_head));
    end
  end

  // Present inputs for one cycle; returns 2 time units after the edge.
  task automatic apply(input bit v, input logic [DW-1:0] d, input bit mr, input bit c);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.m_ready = mr;
    bus.clr     = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    bus.clr     = 1'b0;
    @(posedge clk);
    #2;
    chk("reset m_valid", 32'(bus.m_valid), 32'd0);
    chk("reset s_ready", 32'(bus.s_ready), 32'd1);
    chk("reset occupancy", 32'(bus.occupancy), 32'd0);
    chk("reset m_data", 32'(bus.m_data), 32'd0);
    rst = 1'b0;
    apply(0, '0, 0, 0);
    chk_en = 1'b1;

    // Streaming: one word per cycle, no bubbles
    for (int k = 1; k <= 10; k++) begin
      apply(1, DW'(k), 1, 0);
      chk("stream m_data", 32'(bus.m_data), 32'(k));
      chk("stream m_valid", 32'(bus.m_valid), 32'd1);
      chk("stream occupancy", 32'(bus.occupancy), 32'd1);
    end
    apply(0, '0, 1, 0);
    chk("stream drained", 32'(bus.occupancy), 32'd0);

    // Backpressure into the skid register
    apply(1, 18'h000AA, 0, 0);
    apply(1, 18'h000BB, 0, 0);
    chk("bp occupancy", 32'(bus.occupancy), 32'd2);
    chk("bp s_ready", 32'(bus.s_ready), 32'd0);
    chk("bp m_data", 32'(bus.m_data), 32'h000AA);
    apply(1, 18'h000CC, 0, 0);
    chk("bp hold m_data", 32'(bus.m_data), 32'h000AA);
    chk("bp hold occupancy", 32'(bus.occupancy), 32'd2);
    apply(0, '0, 1, 0);
    chk("bp pop1 m_data", 32'(bus.m_data), 32'h000BB);
    chk("bp pop1 occupancy", 32'(bus.occupancy), 32'd1);
    apply(0, '0, 1, 0);
    chk("bp pop2 occupancy", 32'(bus.occupancy), 32'd0);
    chk("bp pop2 m_valid", 32'(bus.m_valid), 32'd0);

    // Simultaneous push and pop while BUSY
    apply(1, 18'h00011, 0, 0);
    apply(1, 18'h00022, 1, 0);
    chk("pushpop m_data", 32'(bus.m_data), 32'h00022);
    chk("pushpop occupancy", 32'(bus.occupancy), 32'd1);
    apply(0, '0, 1, 0);

    // Flush while FULL, then flush racing a real push in EMPTY
    apply(1, 18'h00044, 0, 0);
    apply(1, 18'h00055, 0, 0);
    chk("flush pre occupancy", 32'(bus.occupancy), 32'd2);
    apply(1, 18'h00033, 0, 1);
    chk("flush occupancy", 32'(bus.occupancy), 32'd0);
    chk("flush m_valid", 32'(bus.m_valid), 32'd0);
    chk("flush s_ready", 32'(bus.s_ready), 32'd1);
    apply(1, 18'h00066, 1, 1);
    chk("flush push discarded", 32'(bus.occupancy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      apply(0, '0, 1, 0);
      chk("flush idle m_valid", 32'(bus.m_valid), 32'd0);
    end

    // Asynchronous reset while FULL
    apply(1, 18'h00077, 0, 0);
    apply(1, 18'h00088, 0, 0);
    chk("rst pre occupancy", 32'(bus.occupancy), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst async m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst async s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst async occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst async m_data", 32'(bus.m_data), 32'd0);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply(0, '0, 1, 0);
      chk("post rst m_valid", 32'(bus.m_valid), 32'd0);
    end

    // Random traffic against the model
    for (int k = 0; k < 10000; k++) begin
      if (!(bus.s_valid && !bus.s_ready)) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data  = DW'($urandom);
      end
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.clr     = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #2;
    end
    apply(0, '0, 1, 0);
    apply(0, '0, 1, 0);
    chk("final drained", 32'(bus.occupancy), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry elastic pipeline stage with valid/ready handshakes on both sides. It is the producer-facing and consumer-facing complement of the plain enabled pipeline register.
- Upstream backpressure replaces the external enable.
- Sits between DSP datapath stages (pre-adder / multiplier / post-adder) so a stalled consumer never drops or duplicates a sample.
- Full throughput: one transfer per cycle. Every output is registered.

Parameters:
- DATA_WIDTH, 18, width of the data word carried through the stage.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous flush: empties the stage, has priority over handshakes.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  stage can accept a word this cycle.
- s_data  input  DATA_WIDTH  upstream word.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word this cycle.
- m_data  output  DATA_WIDTH  output word.
- occupancy  output  2  number of words held (0..2).

Behaviour:
- Handshake rules:
  - Push = s_valid & s_ready. Pop = m_valid & m_ready. Both are sampled on the rising clk edge.
  - m_data/m_valid must stay stable while m_valid=1 and m_ready=0.
  - Upstream must hold s_data stable while s_valid=1 and s_ready=0. The block does not check this.
- Storage: main register (drives m_data) and skid register. All outputs come straight from flops; no combinational path from m_ready to s_ready.
- State EMPTY (occ 0, m_valid 0, s_ready 1):
  - push -> main<=s_data, go to BUSY.
- State BUSY (occ 1, m_valid 1, s_ready 1):
  - push & pop -> main<=s_data, stay in BUSY.
  - push & !pop -> skid<=s_data, go to FULL.
  - !push & pop -> go to EMPTY.
  - otherwise hold.
- State FULL (occ 2, m_valid 1, s_ready 0):
  - pop -> main<=skid, go to BUSY.
  - otherwise hold. Push is impossible in this state.
- Latency: a word pushed at edge N is presented on m_data after edge N (m_valid high in cycle N+1). Order is strictly FIFO.
- clr: at the next edge, go to EMPTY, m_valid=0, s_ready=1, occupancy=0. Data registers keep stale contents. A push coincident with clr is discarded.
- Reset values (asynchronous, immediate on rst high): state EMPTY, m_valid 0, s_ready 1, occupancy 0, m_data 0, skid 0.
- Reset mid-transfer: contents are lost. No word is emitted after reset until a new push.
- Data path is pass-through, no arithmetic or width change.

Decomposition:
- Shared package holds:
  - state encoding constants ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - occupancy width constant OCC_W=2.
- Sub-module pipe_data_reg: DATA_WIDTH-wide register with load enable and asynchronous active-high reset to 0. Instantiated twice (main, skid).
- Handshake FSM lives in the top module.

Test Plan:
- Reset: assert rst mid-cycle with occupancy 2 -> immediately m_valid=0, s_ready=1, occupancy=0, m_data=0.
- Streaming: s_valid=1 and m_ready=1 held, s_data=1,2,3,...,10 on successive cycles -> m_data=1..10 one cycle later, no bubbles, occupancy stays 1.
- Backpressure: push 0x00AA then 0x00BB with m_ready=0 -> occupancy 2, s_ready=0, m_data=0x00AA held stable; raise m_ready for 2 cycles -> 0x00AA then 0x00BB, occupancy 0.
- Simultaneous push/pop in BUSY: main=0x0011, push 0x0022 with m_ready=1 -> next cycle m_data=0x0022, occupancy 1, skid unused.
- Flush: occupancy 2, assert clr with s_valid=1 and s_data=0x0033 -> next cycle occupancy 0, m_valid=0; 0x0033 never appears on m_data.
- Random: random s_valid/m_ready at 50% with a scoreboard, 10,000 cycles -> output sequence equals input sequence, s_ready==(occupancy!=2) every cycle.
